btn_event: RTL
==============

BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001: Parameter LONG_PRESS_CLKS, default 50000000; hold time in clk cycles before a press counts as long (1 s at 50 MHz); SHALL be >= 2.
REQ-002: Parameter REPEAT_CLKS, default 10000000; auto-repeat period in clk cycles while a long press is held (200 ms); SHALL be >= 1.
REQ-003: Parameter CNT_W, default 32; cycle counter width; SHALL hold max(LONG_PRESS_CLKS, REPEAT_CLKS).
REQ-004: clk  input  1  system clock; all state updates on rising edge.
REQ-005: rst  input  1  reset; one clock, synchronous, active-high.
REQ-006: btn_in  input  1  debounced button level from the debouncer; active-low (1 = released, 0 = pressed).
REQ-007: press_pulse  output  1  one-cycle strobe on the press edge.
REQ-008: release_pulse  output  1  one-cycle strobe on the release edge.
REQ-009: short_pulse  output  1  one-cycle strobe on release of a press shorter than LONG_PRESS_CLKS.
REQ-010: long_pulse  output  1  one-cycle strobe when a press reaches LONG_PRESS_CLKS.
REQ-011: repeat_pulse  output  1  one-cycle strobe every REPEAT_CLKS while a long press is held.
REQ-012: held  output  1  level; high while the FSM is in PRESSED or LONG_HELD.

Function
REQ-013: btn_in SHALL be sampled into register btn_q every cycle; a press edge is btn_q=1 with btn_in=0 at a clock edge, a release edge is btn_q=0 with btn_in=1.
REQ-014: All outputs SHALL be registered; each strobe SHALL be high for exactly one cycle, starting the cycle after the clock edge that detects its event.
REQ-015: The FSM SHALL have states IDLE, PRESSED and LONG_HELD.
REQ-016: IDLE -> PRESSED on a press edge: press_pulse asserted, counter cleared to 0.
REQ-017: In PRESSED, the counter SHALL increment by 1 per cycle; when it equals LONG_PRESS_CLKS-1 with no release edge, the FSM SHALL go to LONG_HELD, assert long_pulse and clear the counter, so long_pulse rises exactly LONG_PRESS_CLKS cycles after press_pulse.
REQ-018: PRESSED -> IDLE on a release edge: release_pulse and short_pulse asserted in the same cycle.
REQ-019: In LONG_HELD, the counter SHALL increment per cycle; when it equals REPEAT_CLKS-1 with no release edge, repeat_pulse SHALL be asserted and the counter cleared, giving repeat_pulse every REPEAT_CLKS cycles.
REQ-020: LONG_HELD -> IDLE on a release edge: release_pulse only; short_pulse, long_pulse and repeat_pulse stay low.
REQ-021: When a release edge and a counter threshold fall on the same edge, the release SHALL win: no long_pulse or repeat_pulse; in PRESSED, short_pulse is asserted.
REQ-022: At most one of press_pulse, long_pulse, repeat_pulse SHALL be high in any cycle; short_pulse SHALL only be high together with release_pulse.
REQ-023: The counter SHALL never exceed its threshold minus 1 and SHALL NOT wrap; in IDLE it SHALL hold 0.
REQ-024: The FSM SHALL ignore press edges outside IDLE and release edges in IDLE.

Reset
REQ-025: With rst high at a clock edge: state IDLE, counter 0, btn_q 1, all strobes 0, held 0, from the next cycle.
REQ-026: rst SHALL take priority over every event on the same edge, including pending strobes.
REQ-027: If btn_in is 0 at the first edge after rst deasserts, a press edge SHALL be detected (btn_q reset to 1), and press_pulse is asserted one cycle later.

Verification (LONG_PRESS_CLKS=8, REPEAT_CLKS=4)
REQ-028: btn_in=1 for 100 cycles after reset -> all strobes 0, held 0 throughout.
REQ-029: btn_in low for 5 cycles, then high -> press_pulse 1 cycle, held high; release_pulse+short_pulse together 1 cycle; long_pulse never.
REQ-030: btn_in low for 25 cycles -> press_pulse at T, long_pulse at T+8, repeat_pulse at T+12, T+16, T+20, T+24; on release, release_pulse only.
REQ-031: btn_in released on the edge where the counter equals 7 -> release_pulse+short_pulse, no long_pulse, FSM IDLE.
REQ-032: rst pulsed 1 cycle at T+10 of a long hold, btn_in kept 0 -> outputs and held 0 the cycle after reset; press_pulse 1 cycle after first post-reset edge; long_pulse 8 cycles after that.

Source files
------------

// File: rtl/btn_event.sv
// Button event decoder: turns a debounced active-low button level into
// press/release/short/long/auto-repeat strobes plus a held level.
module btn_event #(
   parameter int unsigned LONG_PRESS_CLKS = 50000000,
   parameter int unsigned REPEAT_CLKS     = 10000000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_CLKS - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CLKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_q;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;

   logic press_edge;
   logic release_edge;

   // btn_in is active-low: a falling level is a press, a rising level a release.
   assign press_edge   = btn_q & ~btn_in;
   assign release_edge = ~btn_q & btn_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= CNT_ZERO;
         btn_q     <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         btn_q     <= btn_in;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = CNT_ZERO;
            if (press_edge) begin
               state_d = PRESSED;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            // A release on the threshold edge wins over the long press.
            if (release_edge) begin
               state_d   = IDLE;
               cnt_d     = CNT_ZERO;
               release_d = 1'b1;
               short_d   = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG_HELD;
               cnt_d   = CNT_ZERO;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         LONG_HELD: begin
            if (release_edge) begin
               state_d   = IDLE;
               cnt_d     = CNT_ZERO;
               release_d = 1'b1;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d    = CNT_ZERO;
               repeat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      held_d = (state_d != IDLE);
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_pulse   = short_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;
   assign state_dbg     = state_q;

endmodule
